// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the pending-write scoreboard: address width default,
// register count derivation and the population-count helper.
package reg_scoreboard_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 5;
    // Widest register file the popcount helper supports (ADDR_W up to 8).
    localparam int unsigned MAX_REGS = 256;

    function automatic int unsigned nregs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Generate-based one-hot address decoder with enable; all-zero output when disabled.
module onehot_decoder #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      a,
    output logic [2**ADDR_W-1:0]   out
);

    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_bit
        assign out[i] = en & (a == ADDR_W'(i));
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: busy bits set at issue, cleared at
// writeback, with RAW/WAW issue stall and a sticky spurious-writeback flag.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter bit          ZERO_HARDWIRED = 1'b1,
    localparam int unsigned NREGS         = nregs(ADDR_W),
    localparam int unsigned CNT_W         = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic              issue_use_rs,
    input  logic              issue_use_rt,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic [CNT_W-1:0]  num_busy,
    output logic              wb_err
);

    // Clears bit 0 of the decoded vectors when register 0 is hardwired.
    localparam logic [NREGS-1:0] KEEP_MASK = ~NREGS'(ZERO_HARDWIRED);

    logic [NREGS-1:0] wb_dec, iss_dec;
    logic [NREGS-1:0] wb_hot, iss_hot, eff;
    logic [NREGS-1:0] busy_d, busy_q;
    logic [CNT_W-1:0] num_busy_d, num_busy_q;
    logic             wb_err_d, wb_err_q;
    logic             iss_en;
    logic             wb_zero;

    onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wb_dec (
        .en  (wb_valid),
        .a   (wb_dst),
        .out (wb_dec)
    );

    onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_iss_dec (
        .en  (iss_en),
        .a   (issue_dst),
        .out (iss_dec)
    );

    // Same-cycle writeback releases the register before the hazard check.
    always_comb begin
        wb_hot = wb_dec & KEEP_MASK;
        eff    = busy_q & ~wb_hot;
        stall  = issue_valid & ((issue_use_rs & eff[issue_rs]) |
                                (issue_use_rt & eff[issue_rt]) |
                                (issue_wr     & eff[issue_dst]));
    end

    assign iss_en  = issue_valid & issue_wr & ~stall;
    assign iss_hot = iss_dec & KEEP_MASK;
    assign wb_zero = ZERO_HARDWIRED && (wb_dst == '0);

    // Set after clear so a same-cycle issue to the retiring register wins.
    always_comb begin
        busy_d     = (busy_q & ~wb_hot) | iss_hot;
        num_busy_d = CNT_W'(popcount(MAX_REGS'(busy_d)));
        wb_err_d   = wb_err_q | (wb_valid & ~busy_q[wb_dst] & ~wb_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            num_busy_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            num_busy_q <= num_busy_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign busy_vec = busy_q;
    assign num_busy = num_busy_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: three configurations driven from one stimulus stream,
// each checked against a per-register array model of the scoreboard rules.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       issue_valid, issue_wr, issue_use_rs, issue_use_rt, wb_valid;
    logic [4:0] issue_dst, issue_rs, issue_rt, wb_dst;

    logic        stall0, stall1, stall2;
    logic [31:0] busy0, busy1;
    logic [7:0]  busy2;
    logic [5:0]  num0, num1;
    logic [3:0]  num2;
    logic        err0, err1, err2;

    int total = 0;
    int bad   = 0;

    // Model configuration per DUT instance: address width and hardwired r0.
    int unsigned aw [3] = '{5, 5, 3};
    bit          zh [3] = '{1'b1, 1'b0, 1'b1};
    bit          mbusy [3][32];
    bit          merr  [3];

    logic [31:0] obs_busy [3];
    logic [31:0] obs_num  [3];
    logic        obs_stall[3];
    logic        obs_err  [3];

    assign obs_busy[0] = busy0;
    assign obs_busy[1] = busy1;
    assign obs_busy[2] = {24'b0, busy2};
    assign obs_num[0]  = {26'b0, num0};
    assign obs_num[1]  = {26'b0, num1};
    assign obs_num[2]  = {28'b0, num2};
    assign obs_stall[0] = stall0;
    assign obs_stall[1] = stall1;
    assign obs_stall[2] = stall2;
    assign obs_err[0]  = err0;
    assign obs_err[1]  = err1;
    assign obs_err[2]  = err2;

    reg_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_dst(issue_dst), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
        .stall(stall0), .busy_vec(busy0), .num_busy(num0), .wb_err(err0)
    );

    reg_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_dst(issue_dst), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
        .stall(stall1), .busy_vec(busy1), .num_busy(num1), .wb_err(err1)
    );

    reg_scoreboard #(.ADDR_W(3), .ZERO_HARDWIRED(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_dst(issue_dst[2:0]), .issue_rs(issue_rs[2:0]), .issue_rt(issue_rt[2:0]),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .wb_valid(wb_valid), .wb_dst(wb_dst[2:0]),
        .stall(stall2), .busy_vec(busy2), .num_busy(num2), .wb_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned msk(input int k, input logic [4:0] a);
        return 32'(a) % (32'd1 << aw[k]);
    endfunction

    // Register still pending once this cycle's writeback is taken into account.
    function automatic bit m_pending(input int k, input int unsigned r);
        bit wb_hit;
        wb_hit = wb_valid && (msk(k, wb_dst) == r) && !(zh[k] && r == 0);
        return mbusy[k][r] && !wb_hit;
    endfunction

    function automatic bit m_stall(input int k);
        if (!issue_valid) return 1'b0;
        return (issue_use_rs && m_pending(k, msk(k, issue_rs))) ||
               (issue_use_rt && m_pending(k, msk(k, issue_rt))) ||
               (issue_wr     && m_pending(k, msk(k, issue_dst)));
    endfunction

    task automatic m_update(input int k, input bit st);
        int unsigned d;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) mbusy[k][r] = 1'b0;
            merr[k] = 1'b0;
        end else begin
            if (wb_valid) begin
                d = msk(k, wb_dst);
                if (!(zh[k] && d == 0)) begin
                    if (!mbusy[k][d]) merr[k] = 1'b1;
                    mbusy[k][d] = 1'b0;
                end
            end
            if (issue_valid && issue_wr && !st) begin
                d = msk(k, issue_dst);
                if (!(zh[k] && d == 0)) mbusy[k][d] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] m_vec(input int k);
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) begin
            if (r < (1 << aw[k])) v[r] = mbusy[k][r];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic wr, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic wbv, input logic [4:0] wbd);
        issue_valid  = v;
        issue_wr     = wr;
        issue_dst    = dst;
        issue_rs     = rs;
        issue_rt     = rt;
        issue_use_rs = urs;
        issue_use_rt = urt;
        wb_valid     = wbv;
        wb_dst       = wbd;
    endtask

    // One clock: check stall before the edge, registered outputs after it.
    task automatic step();
        bit st [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            st[k] = m_stall(k);
            chk("stall", k, {31'b0, obs_stall[k]}, {31'b0, st[k]});
        end
        for (int k = 0; k < 3; k++) m_update(k, st[k]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("busy_vec", k, obs_busy[k], m_vec(k));
            chk("num_busy", k, obs_num[k], popcount(MAX_REGS'(m_vec(k))));
            chk("wb_err", k, {31'b0, obs_err[k]}, {31'b0, merr[k]});
        end
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom % 4 == 0) return 5'($urandom % 32);
        return 5'($urandom_range(0, 9));
    endfunction

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;

        drv(1, 1, 8, 0, 0, 0, 0, 0, 0);          // issue dst=8
        step();
        chk("tp_busy_r8", 0, obs_busy[0], 32'h0000_0100);
        chk("tp_num_one", 0, obs_num[0], 32'd1);
        drv(1, 0, 0, 8, 0, 1, 0, 0, 0);          // RAW on r8
        step();
        drv(1, 1, 8, 8, 0, 1, 0, 1, 8);          // writeback releases, new set wins
        step();
        chk("tp_set_wins", 0, obs_busy[0], 32'h0000_0100);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0);          // issue dst=0
        step();
        chk("tp_r0_hard", 0, obs_busy[0] & 32'h1, 32'h0);
        chk("tp_r0_soft", 1, obs_busy[1] & 32'h1, 32'h1);
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0);          // read r0
        step();
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step();
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0);          // WAW on r3
        step();
        drv(1, 0, 3, 0, 0, 0, 0, 0, 0);          // no write, no sources
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5);          // spurious writeback
        step();
        chk("tp_err_set", 0, {31'b0, obs_err[0]}, 32'h1);
        drv(1, 1, 9, 3, 8, 1, 1, 1, 8);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 3);
        step();
        chk("tp_err_sticky", 0, {31'b0, obs_err[0]}, 32'h1);
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        chk("tp_err_clr", 0, {31'b0, obs_err[0]}, 32'h0);

        for (int r = 0; r < 8; r++) begin
            drv(1, 1, 5'(r), 0, 0, 0, 0, 0, 0);
            step();
        end
        chk("tp_fill_num", 2, obs_num[2], 32'd7);
        chk("tp_fill_vec", 2, obs_busy[2], 32'h0000_00fe);
        rst_n = 1'b0;
        drv(1, 1, 9, 0, 0, 0, 0, 1, 2);
        step();
        rst_n = 1'b1;
        chk("tp_rst_busy", 2, obs_busy[2], 32'h0);
        chk("tp_rst_num", 0, obs_num[0], 32'h0);

        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom % 64) != 0;
            drv(1'($urandom % 4 != 0), 1'($urandom), raddr(), raddr(), raddr(),
                1'($urandom), 1'($urandom), 1'($urandom % 3 == 0), raddr());
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
